// File: rtl/ysyx_22050612_mdu_pkg.sv
// Shared op-code, FSM state and decode helpers for the multiply/divide unit.
// YSYX_22050612_MDU_DIV_EN selects whether divide op-codes are legal.
package ysyx_22050612_mdu_pkg;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd12;
  localparam logic [3:0] OP_DIVUW  = 4'd13;
  localparam logic [3:0] OP_REMW   = 4'd14;
  localparam logic [3:0] OP_REMUW  = 4'd15;

`ifdef YSYX_22050612_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_word(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd10) || (op == 4'd11) || (!DIV_EN && op[2]);
  endfunction

  // Returns {operand A signed, operand B signed}.
  function automatic logic [1:0] is_signed(input logic [3:0] op);
    if (op[2]) return {2{~op[0]}};
    case (op)
      OP_MULH:   return 2'b11;
      OP_MULHSU: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050612_mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per step.
// Only instantiated when YSYX_22050612_MDU_DIV_EN is defined.
module ysyx_22050612_mdu_div_core #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] quot_q, rem_q, dvsr_q, sub_d;
  logic [W:0]   shift_d;
  logic         ge_d;

  // When the shifted remainder is >= divisor the true difference fits in W bits.
  always_comb begin
    shift_d = {rem_q, quot_q[W-1]};
    ge_d    = shift_d >= {1'b0, dvsr_q};
    sub_d   = shift_d[W-1:0] - dvsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      quot_q <= {quot_q[W-2:0], ge_d};
      rem_q  <= ge_d ? sub_d : shift_d[W-1:0];
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/ysyx_22050612_mdu.sv
// Iterative RISC-V M-extension unit: shift-add multiplier plus optional restoring
// divider (built only when YSYX_22050612_MDU_DIV_EN is defined).
module ysyx_22050612_mdu
  import ysyx_22050612_mdu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Z
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_FULL = {1'b1, {(W-1){1'b0}}};
  localparam logic [H-1:0] MIN_HALF = {1'b1, {(H-1){1'b0}}};

  state_e         state_q;
  logic [CW-1:0]  cnt_q, n_q;
  logic [3:0]     op_q;
  logic           a_neg_q, b_neg_q, fast_q, out_valid_q;
  logic [W-1:0]   fast_res_q, z_q, mplier_q;
  logic [2*W-1:0] acc_q, mcand_q;

  logic [1:0]    sgn_d;
  logic          word_d, div_d, ill_d, div0_d, ovf_d, fast_d, a_neg_d, b_neg_d;
  logic [W-1:0]  a_ext_d, b_ext_d, a_sx_d, a_mag_d, b_mag_d, fast_res_d;
  logic [CW-1:0] n_d;

  // Operands are reduced to magnitudes; the sign is reapplied when the result is formed.
  always_comb begin
    sgn_d   = is_signed(op);
    word_d  = is_word(op);
    div_d   = is_div(op);
    ill_d   = is_illegal(op);
    a_ext_d = A;
    b_ext_d = B;
    a_sx_d  = A;
    if (word_d) begin
      a_ext_d = {{H{sgn_d[1] & A[H-1]}}, A[H-1:0]};
      b_ext_d = {{H{sgn_d[0] & B[H-1]}}, B[H-1:0]};
      a_sx_d  = {{H{A[H-1]}}, A[H-1:0]};
    end
    a_neg_d = sgn_d[1] & a_ext_d[W-1];
    b_neg_d = sgn_d[0] & b_ext_d[W-1];
    a_mag_d = a_neg_d ? -a_ext_d : a_ext_d;
    b_mag_d = b_neg_d ? -b_ext_d : b_ext_d;
    div0_d  = !ill_d && div_d && (b_ext_d == '0);
    ovf_d   = !ill_d && div_d && sgn_d[1] &&
              (word_d ? ((A[H-1:0] == MIN_HALF) && (B[H-1:0] == '1))
                      : ((A == MIN_FULL) && (B == '1)));
    fast_d     = ill_d || div0_d || ovf_d;
    fast_res_d = '0;
    if (div0_d)     fast_res_d = op[1] ? a_sx_d : '1;
    else if (ovf_d) fast_res_d = op[1] ? '0 : a_sx_d;
    if (fast_d)      n_d = '0;
    else if (word_d) n_d = CW'(H);
    else             n_d = CW'(W);
  end

  logic accept, step;
  logic [W-1:0] div_quot, div_rem;

  assign accept = (state_q == S_IDLE) && in_valid && !flush;
  assign step   = (state_q == S_BUSY) && (cnt_q != n_q);

`ifdef YSYX_22050612_MDU_DIV_EN
  ysyx_22050612_mdu_div_core #(.W(W)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     (step && op_q[2]),
    .dividend_i (word_d ? {a_mag_d[H-1:0], {H{1'b0}}} : a_mag_d),
    .divisor_i  (b_mag_d),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );
`else
  assign div_quot = '0;
  assign div_rem  = '0;
`endif

  logic [2*W-1:0] prod_d;
  logic [W-1:0]   quot_d, rem_d, res_d, z_d;

  always_comb begin
    prod_d = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quot_d = (a_neg_q ^ b_neg_q) ? -div_quot : div_quot;
    rem_d  = a_neg_q ? -div_rem : div_rem;
    if (fast_q)                                   res_d = fast_res_q;
    else if (op_q[2])                             res_d = op_q[1] ? rem_d : quot_d;
    else if ((op_q == OP_MUL) || (op_q == OP_MULW)) res_d = prod_d[W-1:0];
    else                                          res_d = prod_d[2*W-1:W];
    z_d = op_q[3] ? {{H{res_d[H-1]}}, res_d[H-1:0]} : res_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      op_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      fast_q      <= 1'b0;
      fast_res_q  <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_BUSY;
            cnt_q      <= '0;
            n_q        <= n_d;
            op_q       <= op;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            acc_q      <= '0;
            mcand_q    <= {{W{1'b0}}, a_mag_d};
            mplier_q   <= b_mag_d;
          end
        end
        S_BUSY: begin
          if (cnt_q == n_q) begin
            state_q     <= S_DONE;
            z_q         <= z_d;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q + CW'(1);
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// Scoreboard bench for ysyx_22050612_mdu; expectations follow YSYX_22050612_MDU_DIV_EN.
module tb_ysyx_22050612_mdu;

  localparam int W = 64;
`ifdef YSYX_22050612_MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] A, B, Z;

  typedef struct {
    logic [W-1:0] z;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_22050612_mdu #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [W-1:0] ref_z(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [127:0] pa, pb, p;
    logic [31:0] a32, b32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (o[2] && !DIV_ON) return '0;
    case (o)
      4'd0: return a * b;
      4'd1: begin pa = $signed(a); pb = $signed(b); p = pa * pb; return p[127:64]; end
      4'd2: begin pa = $signed(a); pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'd3: begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'd4: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      4'd5: begin if (b == 0) return '1; return a / b; end
      4'd6: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
        return $signed(a) % $signed(b);
      end
      4'd7: begin if (b == 0) return a; return a % b; end
      4'd8: begin r32 = a32 * b32; return sx32(r32); end
      4'd12: begin
        if (b32 == 0) return '1;
        if (a32 == 32'h8000_0000 && b32 == '1) return sx32(a32);
        r32 = $signed(a32) / $signed(b32);
        return sx32(r32);
      end
      4'd13: begin if (b32 == 0) return '1; r32 = a32 / b32; return sx32(r32); end
      4'd14: begin
        if (b32 == 0) return sx32(a32);
        if (a32 == 32'h8000_0000 && b32 == '1) return '0;
        r32 = $signed(a32) % $signed(b32);
        return sx32(r32);
      end
      4'd15: begin if (b32 == 0) return sx32(a32); r32 = a32 % b32; return sx32(r32); end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (o == 4'd9 || o == 4'd10 || o == 4'd11) return 1;
    if (o[2]) begin
      if (!DIV_ON) return 1;
      if (o[3]) begin
        if (b[31:0] == 0) return 1;
        if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
        return 33;
      end
      if (b == 0) return 1;
      if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
      return 65;
    end
    return o[3] ? 33 : 65;
  endfunction

  // Drive one request, then compare latency and result from the scoreboard.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit use_z, input logic [W-1:0] zfix);
    exp_t e;
    int   n;
    bit   seen;
    e.z   = (use_z && (DIV_ON || !o[2])) ? zfix : ref_z(o, a, b);
    e.lat = ref_lat(o, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    op = o; A = a; B = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); A = {$urandom, $urandom}; B = {$urandom, $urandom};
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = out_valid;
    end
    e = exp_q.pop_front();
    chk("latency", 64'(n), 64'(e.lat));
    chk("z", Z, e.z);
    $display("txn op=%0d a=%h b=%h z=%h exp=%h lat=%0d hold=%0d", o, a, b, Z, e.z, n, hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_z", Z, e.z);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ret_ready", 64'(in_ready), 64'd1);
    chk("ret_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_z", Z, 64'd0);

    run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4'd3, '1, '1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(4'd1, '1, '1, 0, 1, 64'd0);
    run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd5, 64'd12345, 64'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd4, 64'h8000_0000_0000_0000, '1, 0, 1, 64'h8000_0000_0000_0000);
    run_op(4'd12, 64'h1_8000_0000, '1, 0, 1, 64'hFFFF_FFFF_8000_0000);
    run_op(4'd8, 64'h1_0000_0003, 64'h4000_0000, 0, 1, 64'hFFFF_FFFF_C000_0000);
    run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 0, 0, '0);
    run_op(4'd7, 64'd100, 64'd7, 0, 0, '0);
    run_op(4'd13, 64'h0000_0001_FFFF_FFF0, 64'd3, 0, 0, '0);
    run_op(4'd14, 64'hFFFF_FFF9, 64'd2, 0, 0, '0);
    run_op(4'd15, 64'hDEAD_0000_0009, 64'd0, 0, 0, '0);
    run_op(4'd9, 64'd5, 64'd6, 0, 1, 64'd0);
    run_op(4'd11, 64'd5, 64'd6, 0, 1, 64'd0);
    run_op(4'd0, 64'd123, 64'd456, 5, 0, '0);

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      run_op(ro, ra, rb, 0, 0, '0);
    end

    // Flush part-way through a multiply while a new request is offered.
    @(negedge clk);
    op = 4'd0; A = 64'd9; B = 64'd11; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_ready", 64'(in_ready), 64'd0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 4'd3; A = '1; B = '1;
    @(posedge clk); #1;
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_noaccept", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    quiet("flush_quiet", 80);
    run_op(4'd0, 64'd6, 64'd7, 0, 1, 64'd42);

    // Reset mid-operation overrides flush and in_valid.
    @(negedge clk);
    op = 4'd0; A = 64'd5; B = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_z", Z, 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    quiet("rst_quiet", 80);
    run_op(4'd3, 64'h1_0000_0000, 64'h1_0000_0000, 0, 1, 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
